// File: rtl/ram_access_ctrl_pkg.sv
// ram_access_ctrl_pkg
// Shared definitions for the data-RAM initiator and the instruction-fetch
// side: FSM state encoding, the byte-to-word shift and an address check.
//   st_idle / st_access / st_resp : 2-bit FSM state constants
//   WORD_SHIFT                    : log2 of the 8-byte word size
//   addr_is_bad()                 : misaligned or beyond the RAM depth
package ram_access_ctrl_pkg;

    typedef logic [1:0] state_t;

    localparam state_t st_idle   = 2'd0;
    localparam state_t st_access = 2'd1;
    localparam state_t st_resp   = 2'd2;

    localparam int WORD_SHIFT = 3;

    // A request is rejected when it is not on an 8-byte boundary or when any
    // byte-address bit above the word index is set.
    function automatic logic addr_is_bad(input logic [63:0] addr, input int addr_w);
        logic [63:0] upper;
        upper = addr >> (addr_w + WORD_SHIFT);
        return (addr[WORD_SHIFT-1:0] != '0) || (upper != '0);
    endfunction

endpackage

// File: rtl/ram_access_ctrl_if.sv
// ram_access_ctrl_if
// Request/response channel between the CPU memory stage (master) and the
// RAM initiator (slave).
//   req_valid/req_ready : request handshake
//   req_write           : 1 = store, 0 = load
//   req_addr            : 64-bit byte address
//   req_wdata           : store data
//   rsp_valid/rsp_ready : response handshake
//   rsp_rdata           : load data (0 for stores and errors)
//   rsp_err             : request rejected
interface ram_access_ctrl_if #(
    parameter int DATA_W = 64
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [63:0]       req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/ram_access_ctrl_sat_counter.sv
// sat_counter
// Event counter that sticks at its maximum value instead of wrapping.
//   clock, reset_n : clock and asynchronous active-low reset
//   inc            : count one event this cycle
//   count          : current count
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl
// Initiator for the 2**ADDR_W x DATA_W data RAM. Accepts load/store requests,
// drives the RAM pins for exactly one cycle (the RAM samples at the negedge),
// and returns data/status on the response channel. Keeps saturating counts.
//   clock, reset_n          : system clock, asynchronous active-low reset
//   bus (slave)             : request/response channel
//   address, in, write      : RAM address, write data and write enable
//   Out                     : RAM read data (updates at negedge)
//   ld_count, st_count,
//   err_count               : completed loads/stores, rejected requests
module ram_access_ctrl
    import ram_access_ctrl_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 64,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    ram_access_ctrl_if.slave  bus,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] in,
    output logic              write,
    input  logic [DATA_W-1:0] Out,
    output logic [CNT_W-1:0]  ld_count,
    output logic [CNT_W-1:0]  st_count,
    output logic [CNT_W-1:0]  err_count
);

    state_t state;
    logic   accept;
    logic   bad;

    // req_ready is gated by reset_n so nothing is accepted while reset is held
    assign bus.req_ready = reset_n && (state == st_idle);
    assign bus.rsp_valid = (state == st_resp);
    assign accept        = bus.req_valid && bus.req_ready;
    assign bad           = addr_is_bad(bus.req_addr, ADDR_W);

    // Reset clears write immediately, so a store whose negedge has not yet
    // arrived never reaches the RAM. The write flag doubles as the
    // load/store marker during the ACCESS cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= st_idle;
            address       <= '0;
            in            <= '0;
            write         <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
        end else begin
            case (state)
                st_idle: begin
                    if (accept) begin
                        if (bad) begin
                            bus.rsp_err   <= 1'b1;
                            bus.rsp_rdata <= '0;
                            state         <= st_resp;
                        end else begin
                            address <= bus.req_addr[ADDR_W+WORD_SHIFT-1:WORD_SHIFT];
                            in      <= bus.req_wdata;
                            write   <= bus.req_write;
                            state   <= st_access;
                        end
                    end
                end
                st_access: begin
                    write         <= 1'b0;
                    bus.rsp_rdata <= write ? '0 : Out;
                    bus.rsp_err   <= 1'b0;
                    state         <= st_resp;
                end
                st_resp: begin
                    if (bus.rsp_ready) begin
                        state <= st_idle;
                    end
                end
                default: state <= st_idle;
            endcase
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_ld_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .inc     ((state == st_access) && !write),
        .count   (ld_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_st_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .inc     ((state == st_access) && write),
        .count   (st_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .inc     (accept && bad),
        .count   (err_count)
    );

endmodule

// File: tb/tb_ram_access_ctrl.sv
// tb_ram_access_ctrl
// Self-checking bench for ram_access_ctrl with a behavioural 256x64 RAM
// (negedge write, negedge registered read) and a reference model built
// from byte-address arithmetic, a word array and saturating counts.
module tb_ram_access_ctrl;

    logic        clock   = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  address;
    logic [63:0] in_w;
    logic        write;
    logic [63:0] ram_out;
    logic [15:0] ld_count, st_count, err_count;

    ram_access_ctrl_if #(.DATA_W(64)) bus ();

    ram_access_ctrl #(.ADDR_W(8), .DATA_W(64), .CNT_W(16)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .bus       (bus),
        .address   (address),
        .in        (in_w),
        .write     (write),
        .Out       (ram_out),
        .ld_count  (ld_count),
        .st_count  (st_count),
        .err_count (err_count)
    );

    always #5 clock = ~clock;

    // RAM256x64 behavioural model: samples pins at the negedge
    logic [63:0] ram [0:255];
    always @(negedge clock) begin
        if (write === 1'b1) ram[address] <= in_w;
        ram_out <= ram[address];
    end

    int cyc     = 0;
    int wr_high = 0;
    always @(posedge clock) cyc++;
    always @(negedge clock) if (write === 1'b1) wr_high++;

    int checks   = 0;
    int failures = 0;

    logic [63:0] mem_model [0:255];
    int ld_m = 0, st_m = 0, err_m = 0;

    function automatic int sat_inc(input int x);
        return (x < 65535) ? x + 1 : x;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_counters();
        check("ld_count", 64'(ld_count), 64'(ld_m));
        check("st_count", 64'(st_count), 64'(st_m));
        check("err_count", 64'(err_count), 64'(err_m));
    endtask

    // One complete transaction; returns the cycle in which it was accepted
    task automatic do_req(input logic wr, input logic [63:0] addr,
                          input logic [63:0] wdata, input int hold, output int acc);
        bit          bad;
        int          idx;
        int          w0;
        int          budget;
        logic [63:0] exp_rdata;
        bad = (addr % 64'd8 != 64'd0) || (addr >= 64'd2048);
        idx = int'(addr / 64'd8);
        w0  = wr_high;
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        budget = 0;
        while (bus.req_ready !== 1'b1 && budget < 20) begin step(); budget++; end
        check("req_ready_wait", 64'(budget < 20), 64'd1);
        acc = cyc;
        step();
        bus.req_valid = 1'b0;
        bus.req_write = 1'($urandom);
        bus.req_addr  = {32'($urandom), 32'($urandom)};
        bus.req_wdata = {32'($urandom), 32'($urandom)};
        budget = 0;
        while (bus.rsp_valid !== 1'b1 && budget < 20) begin step(); budget++; end
        check("rsp_latency", 64'(cyc - acc), bad ? 64'd1 : 64'd2);
        if (bad) begin
            exp_rdata = '0;
            err_m = sat_inc(err_m);
        end else if (wr) begin
            exp_rdata = '0;
            mem_model[idx] = wdata;
            st_m = sat_inc(st_m);
        end else begin
            exp_rdata = mem_model[idx];
            ld_m = sat_inc(ld_m);
        end
        check("rsp_err", 64'(bus.rsp_err), 64'(bad));
        check("rsp_rdata", bus.rsp_rdata, exp_rdata);
        if (!bad) check("address", 64'(address), 64'(idx));
        for (int k = 0; k < hold; k++) begin
            step();
            check("hold_rsp_valid", 64'(bus.rsp_valid), 64'd1);
            check("hold_req_ready", 64'(bus.req_ready), 64'd0);
            check("hold_rsp_rdata", bus.rsp_rdata, exp_rdata);
            check("hold_rsp_err", 64'(bus.rsp_err), 64'(bad));
        end
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        check("write_cycles", 64'(wr_high - w0), (wr && !bad) ? 64'd1 : 64'd0);
        check_counters();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          a0, a1, a2, a3;
        logic [63:0] addr, wdata, snap;
        int          kind;

        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 256; i++) begin
            wdata = {32'($urandom), 32'($urandom)};
            ram[i] <= wdata;
            mem_model[i] = wdata;
        end

        // reset state
        step();
        step();
        check("rst_req_ready", 64'(bus.req_ready), 64'd0);
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("rst_rsp_err", 64'(bus.rsp_err), 64'd0);
        check("rst_rsp_rdata", bus.rsp_rdata, 64'd0);
        check("rst_write", 64'(write), 64'd0);
        check("rst_address", 64'(address), 64'd0);
        check("rst_in", in_w, 64'd0);
        check_counters();
        reset_n = 1'b1;
        step();

        // store then load at 0x10
        do_req(1'b1, 64'h10, 64'hDEAD_BEEF_0123_4567, 0, a0);
        do_req(1'b0, 64'h10, 64'h0, 0, a0);
        check("t1_rdata_const", mem_model[2], 64'hDEAD_BEEF_0123_4567);

        // misaligned load and out-of-range store
        snap = mem_model[1];
        do_req(1'b0, 64'h0C, 64'h0, 0, a0);
        do_req(1'b1, 64'h800, 64'h1111_2222_3333_4444, 0, a0);
        check("t2_ram_word1", ram[1], snap);

        // top word round-trip and one past the end
        do_req(1'b1, 64'h7F8, 64'hA5A5_5A5A_F00D_CAFE, 1, a0);
        do_req(1'b0, 64'h7F8, 64'h0, 0, a0);
        do_req(1'b0, 64'h800, 64'h0, 0, a0);

        // back-to-back loads, then a 5-cycle stall
        bus.rsp_ready = 1'b1;
        do_req(1'b0, 64'h18, 64'h0, 0, a0);
        do_req(1'b0, 64'h20, 64'h0, 0, a1);
        do_req(1'b0, 64'h28, 64'h0, 0, a2);
        check("b2b_gap1", 64'(a1 - a0), 64'd3);
        check("b2b_gap2", 64'(a2 - a1), 64'd3);
        do_req(1'b0, 64'h30, 64'h0, 5, a3);

        // reset during the ACCESS cycle of a store, before its negedge
        snap  = mem_model[5];
        wdata = ~snap;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 64'h28;
        bus.req_wdata = wdata;
        step();
        bus.req_valid = 1'b0;
        check("t5_write_before", 64'(write), 64'd1);
        reset_n = 1'b0;
        #1;
        check("t5_write_cleared", 64'(write), 64'd0);
        ld_m = 0; st_m = 0; err_m = 0;
        step();
        step();
        check("t5_req_ready", 64'(bus.req_ready), 64'd0);
        check("t5_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("t5_ram_word", ram[5], snap);
        check_counters();
        reset_n = 1'b1;
        step();
        check("t5_no_rsp", 64'(bus.rsp_valid), 64'd0);
        do_req(1'b0, 64'h28, 64'h0, 0, a0);

        // load counter saturation
        force dut.u_ld_cnt.count = 16'hFFFE;
        #1;
        release dut.u_ld_cnt.count;
        ld_m = 65534;
        for (int i = 0; i < 3; i++) do_req(1'b0, 64'(i) * 64'd8, 64'h0, 0, a0);

        // randomized mix of good, misaligned and out-of-range accesses
        for (int i = 0; i < 24; i++) begin
            kind = int'($urandom_range(0, 3));
            if (kind <= 1) addr = 64'($urandom_range(0, 255)) * 64'd8;
            else if (kind == 2) addr = 64'($urandom_range(0, 255)) * 64'd8 + 64'($urandom_range(1, 7));
            else begin
                addr = {32'($urandom), 32'($urandom)};
                if (addr < 64'd2048) addr = addr + 64'd2048;
            end
            wdata = {32'($urandom), 32'($urandom)};
            do_req(1'($urandom), addr, wdata, int'($urandom_range(0, 2)), a0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
